five_bit_xor: RTL and testbench
===============================

FIVE_BIT_XOR -- requirements
Module: five_bit_xor

Interface
REQ-001 Parameter: WIDTH, 5, operand/result width; all requirements below hold for WIDTH=5, the only supported value.
REQ-002 clk  input  1  single clock, all registers update on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sum  output  5  combinational bitwise XOR of a and b.
REQ-005 a  input  5  operand A.
REQ-006 b  input  5  operand B.
REQ-007 in_valid  input  1  qualifies a/b for the registered path.
REQ-008 sum_q  output  5  registered copy of sum captured when in_valid=1.
REQ-009 out_valid  output  1  high for one cycle after each captured operand pair.
REQ-010 parity_q  output  1  XOR-reduction of sum_q (odd number of differing bits).
REQ-011 equal_q  output  1  high when the captured a equalled b (sum_q==0).
REQ-012 diff_cnt_q  output  3  population count of sum_q (0..5).

Function
REQ-013 sum[i] SHALL equal a[i] XOR b[i] for i=0..4, purely combinational, zero-cycle latency, independent of clk, rst and in_valid.
REQ-014 sum SHALL update in the same delta/time step as any change on a or b; no glitch filtering is required.
REQ-015 On a rising clk edge with in_valid=1, sum_q SHALL load a^b, and parity_q, equal_q and diff_cnt_q SHALL load values derived from that same a^b.
REQ-016 On a rising clk edge with in_valid=0, sum_q, parity_q, equal_q and diff_cnt_q SHALL hold their values.
REQ-017 out_valid SHALL equal in_valid registered by one cycle (latency exactly 1 cycle; back-to-back in_valid yields back-to-back out_valid).
REQ-018 diff_cnt_q SHALL be an unsigned 3-bit count; its maximum value of 5 SHALL not overflow.
REQ-019 equal_q SHALL be 1 if and only if diff_cnt_q==0; parity_q SHALL equal diff_cnt_q[0].
REQ-020 If rst asserts mid-operation, all registers SHALL clear immediately; sum SHALL still follow a^b.

Reset
REQ-021 While rst=1: sum_q=5'b00000, out_valid=0, parity_q=0, equal_q=1, diff_cnt_q=0, asynchronously.
REQ-022 The first capture SHALL occur on the first rising edge with rst=0 and in_valid=1.

Structure
REQ-023 The shared package SHALL hold WIDTH=5 and the count width (3); no typedefs are required.
REQ-024 The per-bit XOR SHALL be a sub-module xor_1bit (output, in1, in2), instantiated 5 times to form sum.
REQ-025 The popcount and registered flags SHALL reside in five_bit_xor itself.

Verification
REQ-026 a=00001, b=00001 -> sum=00000; after a clocked capture: equal_q=1, parity_q=0, diff_cnt_q=0.
REQ-027 a=00011, b=00010 -> sum=00001; a=00111, b=00000 -> sum=00111; a=11111, b=00000 -> sum=11111, diff_cnt_q=5 after capture, parity_q=1.
REQ-028 a=00001, b=00100 -> sum=00101; a=01100, b=01110 -> sum=00010; a=01010, b=10001 -> sum=11011, diff_cnt_q=4, parity_q=0; each sum is checked 20 time units after the operand change, with no clock required.
REQ-029 Drive in_valid high for 3 consecutive cycles -> out_valid is high for exactly 3 cycles, delayed by 1; with in_valid low, sum_q holds while sum still tracks the inputs.
REQ-030 Assert rst asynchronously between clock edges after a capture of 11111 -> sum_q=0, equal_q=1, out_valid=0 immediately; sum remains a^b.

Source files
------------

// File: rtl/five_bit_xor_pkg.sv
// Shared widths for the five-bit XOR datapath and its registered popcount.
package five_bit_xor_pkg;

    localparam int unsigned WIDTH     = 5;
    localparam int unsigned CNT_WIDTH = 3;

endpackage

// File: rtl/xor_1bit.sv
// Single-bit XOR cell; five_bit_xor builds its combinational sum from these.
module xor_1bit (
    output logic out,
    input  logic in1,
    input  logic in2
);

    assign out = in1 ^ in2;

endmodule

// File: rtl/five_bit_xor.sv
// Five-bit XOR with a combinational result and a registered copy carrying
// parity, equality and population-count flags.
module five_bit_xor
    import five_bit_xor_pkg::*;
#(
    parameter int unsigned WIDTH = five_bit_xor_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     sum,
    output logic [WIDTH-1:0]     sum_q,
    output logic                 out_valid,
    output logic                 parity_q,
    output logic                 equal_q,
    output logic [CNT_WIDTH-1:0] diff_cnt_q
);

    logic [CNT_WIDTH-1:0] diff_cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_xor
        xor_1bit u_xor_1bit (
            .out (sum[i]),
            .in1 (a[i]),
            .in2 (b[i])
        );
    end

    // Three bits hold the maximum count of five without overflow.
    always_comb begin
        diff_cnt_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            diff_cnt_d = diff_cnt_d + {{(CNT_WIDTH-1){1'b0}}, sum[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q      <= '0;
            out_valid  <= 1'b0;
            parity_q   <= 1'b0;
            equal_q    <= 1'b1;
            diff_cnt_q <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q      <= sum;
                parity_q   <= diff_cnt_d[0];
                equal_q    <= (diff_cnt_d == '0);
                diff_cnt_q <= diff_cnt_d;
            end
        end
    end

endmodule

// File: tb/tb_five_bit_xor.sv
// Directed and random checks of five_bit_xor against a bit-counting reference model.
module tb_five_bit_xor;

    logic       clk;
    logic       rst;
    logic [4:0] a;
    logic [4:0] b;
    logic       in_valid;
    logic [4:0] sum;
    logic [4:0] sum_q;
    logic       out_valid;
    logic       parity_q;
    logic       equal_q;
    logic [2:0] diff_cnt_q;

    int unsigned vectors;
    int unsigned miscompares;

    // Reference state: last captured difference pattern and its count.
    logic [4:0] m_sum;
    int         m_cnt;
    logic       m_valid;

    five_bit_xor dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .sum        (sum),
        .sum_q      (sum_q),
        .out_valid  (out_valid),
        .parity_q   (parity_q),
        .equal_q    (equal_q),
        .diff_cnt_q (diff_cnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int count_diff(input logic [4:0] x, input logic [4:0] y);
        int n = 0;
        for (int i = 0; i < 5; i++) begin
            if (x[i] != y[i]) n++;
        end
        return n;
    endfunction

    function automatic logic [4:0] diff_pattern(input logic [4:0] x, input logic [4:0] y);
        logic [4:0] p = '0;
        for (int i = 0; i < 5; i++) begin
            p[i] = (x[i] != y[i]);
        end
        return p;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".sum_q"}, {3'b0, sum_q}, {3'b0, m_sum});
        check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, m_valid});
        check({tag, ".parity_q"}, {7'b0, parity_q}, {7'b0, logic'(m_cnt % 2 == 1)});
        check({tag, ".equal_q"}, {7'b0, equal_q}, {7'b0, logic'(m_cnt == 0)});
        check({tag, ".diff_cnt_q"}, {5'b0, diff_cnt_q}, 8'(m_cnt));
    endtask

    task automatic model_reset();
        m_sum   = '0;
        m_cnt   = 0;
        m_valid = 1'b0;
    endtask

    // Drive operands just after an edge, check sum, clock once, check registers.
    task automatic step(input string tag, input logic [4:0] av, input logic [4:0] bv,
                        input logic v);
        a        = av;
        b        = bv;
        in_valid = v;
        #1;
        check({tag, ".sum"}, {3'b0, sum}, {3'b0, diff_pattern(av, bv)});
        @(posedge clk);
        if (v) begin
            m_sum = diff_pattern(av, bv);
            m_cnt = count_diff(av, bv);
        end
        m_valid = v;
        #1;
        check_regs(tag);
    endtask

    task automatic comb_only(input string tag, input logic [4:0] av, input logic [4:0] bv);
        a = av;
        b = bv;
        #20;
        check({tag, ".sum"}, {3'b0, sum}, {3'b0, diff_pattern(av, bv)});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        a           = 5'b00000;
        b           = 5'b00000;
        in_valid    = 1'b0;
        model_reset();

        #2;
        check_regs("reset");
        a = 5'b10110;
        b = 5'b00011;
        #1;
        check("reset.sum_tracks", {3'b0, sum}, 8'h15);
        #9;
        rst = 1'b0;  // t=12, between edges

        step("r026", 5'b00001, 5'b00001, 1'b1);
        step("r027a", 5'b00011, 5'b00010, 1'b1);
        step("r027b", 5'b00111, 5'b00000, 1'b1);
        step("r027c", 5'b11111, 5'b00000, 1'b1);
        check("r027c.cnt5", {5'b0, diff_cnt_q}, 8'd5);
        check("r027c.par1", {7'b0, parity_q}, 8'd1);

        in_valid = 1'b0;
        comb_only("r028a", 5'b00001, 5'b00100);
        comb_only("r028b", 5'b01100, 5'b01110);
        comb_only("r028c", 5'b01010, 5'b10001);
        check("r028c.value", {3'b0, sum}, 8'h1b);
        @(posedge clk);
        m_valid = 1'b0;
        #1;
        check_regs("r028.hold");
        step("r028d", 5'b01010, 5'b10001, 1'b1);
        check("r028d.cnt4", {5'b0, diff_cnt_q}, 8'd4);
        check("r028d.par0", {7'b0, parity_q}, 8'd0);

        // Three back-to-back captures, then idle cycles with changing operands.
        step("r029v0", 5'b10000, 5'b00001, 1'b1);
        step("r029v1", 5'b11000, 5'b00111, 1'b1);
        step("r029v2", 5'b00110, 5'b00110, 1'b1);
        step("r029i0", 5'b11111, 5'b01010, 1'b0);
        step("r029i1", 5'b00101, 5'b11100, 1'b0);

        // Asynchronous reset between edges after capturing 11111.
        step("r030cap", 5'b11111, 5'b00000, 1'b1);
        in_valid = 1'b0;
        a        = 5'b11001;
        b        = 5'b00011;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_regs("r030");
        check("r030.sum", {3'b0, sum}, 8'h1a);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_regs("r030.after");

        for (int i = 0; i < 60; i++) begin
            step("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
